// File: rtl/prn_arbiter_if.sv
// Bundles the request, generator and grant signals between requesters/PRN generator and prn_arbiter.
// Latency: none, wires only.
// Backpressure: none here; requesters hold req until gnt, and the arbiter paces the generator via lfsr_step.
interface prn_arbiter_if;
  logic [3:0] req;
  logic [1:0] mode;
  logic [4:0] prn_in;
  logic       easy_t;
  logic       normal_t;
  logic       extreme_t;
  logic       lfsr_step;
  logic [3:0] gnt;
  logic [4:0] rnd_out;
  logic       spawn;
  logic       busy;

  // Requester/generator side drives requests and random data, observes grants.
  modport master (
    output req, mode, prn_in, easy_t, normal_t, extreme_t,
    input  lfsr_step, gnt, rnd_out, spawn, busy
  );

  // Arbiter side.
  modport slave (
    input  req, mode, prn_in, easy_t, normal_t, extreme_t,
    output lfsr_step, gnt, rnd_out, spawn, busy
  );
endinterface

// File: rtl/prn_arbiter.sv
// Round-robin arbiter that steps the PRN generator STEP_CNT times, samples it, and grants one requester.
// Latency: req seen in IDLE -> STEP_CNT step cycles -> one sample cycle -> one-cycle gnt (STEP_CNT+2 cycles).
// Backpressure: requester must hold req until gnt; dropping req[winner] mid-transaction aborts with no gnt.
// Optional: define PRN_SPAWN_LIMIT_EN to suppress a requester's third consecutive spawn.
module prn_arbiter #(
  parameter int unsigned STEP_CNT = 3
) (
  input  logic          clk,
  input  logic          rst,
  prn_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, STEP, SAMPLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [1:0] rr_ptr;
  logic [1:0] winner;
  logic [1:0] mode_l;
  logic [3:0] cnt;
  logic [4:0] rnd_r;
  logic       spawn_r;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       any_req;
  logic       win_req;
  logic       sel_flag;
  logic       spawn_eff;

  assign any_req = |bus.req;
  assign win_req = bus.req[winner];

  // Winner search: first set req bit at or after rr_ptr, wrapping 3 -> 0.
  always_comb begin
    pick = rr_ptr;
    idx  = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (bus.req[idx]) pick = idx;
    end
  end

  // Threshold flag chosen by the mode latched at winner selection; spawn-off gives 0.
  always_comb begin
    sel_flag = 1'b0;
    case (mode_l)
      2'd0:    sel_flag = bus.easy_t;
      2'd1:    sel_flag = bus.normal_t;
      2'd2:    sel_flag = bus.extreme_t;
      default: sel_flag = 1'b0;
    endcase
  end

`ifdef PRN_SPAWN_LIMIT_EN
  logic [3:0][1:0] sp_cnt;

  // A third consecutive spawn for the same requester is forced to 0.
  always_comb begin
    spawn_eff = sel_flag && (sp_cnt[winner] != 2'd2);
  end

  // Per-requester consecutive-spawn counters, updated only when a grant is committed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_cnt <= '0;
    end else if (state == SAMPLE && win_req) begin
      if (spawn_eff) sp_cnt[winner] <= sp_cnt[winner] + 2'd1;
      else           sp_cnt[winner] <= 2'd0;
    end
  end
`else
  // Without the limiter the spawn decision is the selected flag.
  always_comb begin
    spawn_eff = sel_flag;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; losing req[winner] during STEP or SAMPLE abandons the transaction.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = STEP;
      STEP:    if (!win_req) state_nxt = IDLE;
               else if (cnt == 4'd1) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = win_req ? GRANT : IDLE;
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch winner/mode/count, count steps, capture the sample, advance rr_ptr after a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      winner  <= '0;
      mode_l  <= '0;
      cnt     <= '0;
      rnd_r   <= '0;
      spawn_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            winner <= pick;
            mode_l <= bus.mode;
            cnt    <= 4'(STEP_CNT);
          end
        end
        STEP: begin
          cnt <= win_req ? cnt - 4'd1 : 4'd0;
        end
        SAMPLE: begin
          // Loaded at entry to GRANT so the values appear with gnt and hold until the next grant.
          if (win_req) begin
            rnd_r   <= bus.prn_in;
            spawn_r <= spawn_eff;
          end
        end
        GRANT: begin
          rr_ptr <= winner + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so reset clears them immediately.
  always_comb begin
    bus.lfsr_step = (state == STEP);
    bus.busy      = (state != IDLE);
    bus.gnt       = (state == GRANT) ? (4'b0001 << winner) : 4'b0000;
    bus.rnd_out   = rnd_r;
    bus.spawn     = spawn_r;
  end

endmodule

// File: doc/prn_arbiter.md
PRN_ARBITER -- requirements
Module: prn_arbiter

Interface
REQ-001 Parameter: STEP_CNT, 3, number of lfsr_step cycles issued per transaction; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester request level; bit i is requester i.
REQ-005 mode  input  2  difficulty: 0 easy, 1 normal, 2 extreme, 3 spawn-off.
REQ-006 prn_in  input  5  current value from the 5-bit pseudo-random generator.
REQ-007 easy_t, normal_t, extreme_t  input  1 each  spawn-threshold flags from the generator.
REQ-008 lfsr_step  output  1  enable pulse that advances the generator one step per cycle high.
REQ-009 gnt  output  4  one-hot, one-cycle grant to the served requester.
REQ-010 rnd_out  output  5  random value delivered with the grant.
REQ-011 spawn  output  1  spawn decision delivered with the grant.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, STEP, SAMPLE, GRANT; there are no other reachable states.
REQ-014 IDLE: if any req bit is high, the winner is the first set bit at or after rr_ptr (wrapping 3->0); winner, mode and STEP_CNT load on that edge; next state is STEP.
REQ-015 STEP: lfsr_step=1 for exactly STEP_CNT consecutive cycles; a down-counter tracks them; then SAMPLE.
REQ-016 SAMPLE: lfsr_step=0; prn_in and the threshold flag selected by the latched mode are captured at end of cycle; then GRANT.
REQ-017 Spawn select: mode 0 -> easy_t, 1 -> normal_t, 2 -> extreme_t, 3 -> 0.
REQ-018 GRANT: gnt[winner]=1 for exactly one cycle; rnd_out and spawn take the captured values in that same cycle and hold until the next GRANT.
REQ-019 After GRANT, rr_ptr = (winner+1) mod 4; next state is IDLE; no back-to-back grant without passing through IDLE.
REQ-020 Latency: req seen in IDLE in cycle 0 -> lfsr_step in cycles 1..STEP_CNT -> SAMPLE in cycle STEP_CNT+1 -> gnt in cycle STEP_CNT+2.
REQ-021 A requester holds req until its gnt; if req[winner] falls during STEP or SAMPLE, the transaction aborts to IDLE, with no gnt, rr_ptr unchanged, and rnd_out/spawn unchanged.
REQ-022 Changes on mode or on non-winner req bits after winner latch SHALL NOT affect the current transaction.
REQ-023 All four req high continuously SHALL be served in rotation 0,1,2,3,0,...; no requester waits more than 3 other grants.
REQ-024 gnt SHALL never have more than one bit set; lfsr_step SHALL be 0 outside STEP.

Reset
REQ-025 rst low SHALL immediately force: state IDLE, rr_ptr 0, counter 0, gnt 0, lfsr_step 0, rnd_out 0, spawn 0, busy 0, and clear any limit counters.
REQ-026 Reset asserted mid-transaction SHALL discard it with no gnt; after release, operation restarts from IDLE with rr_ptr 0.

Configuration
REQ-027 Macro PRN_SPAWN_LIMIT_EN defined: each requester has a 2-bit consecutive-spawn counter; a grant that would be that requester's 3rd consecutive spawn=1 SHALL deliver spawn=0 and clear its counter; a spawn=0 grant clears its counter.
REQ-028 Macro PRN_SPAWN_LIMIT_EN undefined: no counters exist and spawn always equals the selected flag per REQ-017.

Verification
REQ-029 Scenario: STEP_CNT=3, rst released, req=0001 held, prn_in=5'h0B, mode=1, normal_t=1 -> lfsr_step cycles 1-3, gnt=0001 in cycle 5, rnd_out=0B, spawn=1.
REQ-030 Scenario: req=1111 held through 8 grants -> gnt order 0001,0010,0100,1000,0001,0010,0100,1000, with each gnt one cycle wide.
REQ-031 Scenario: req=0100 dropped in cycle 2 -> no gnt, busy=0 by cycle 4, rr_ptr still 0 (next req=0101 grants 0001 first).
REQ-032 Scenario: mode=3, extreme_t=1, req=0010 -> gnt=0010, spawn=0; mode switched to 0 during STEP SHALL still give spawn=0.
REQ-033 Scenario: rst driven low in cycle 2 of STEP -> all outputs 0 in the same cycle, no gnt ever issued for that transaction.
REQ-034 Scenario (PRN_SPAWN_LIMIT_EN): requester 0 gets 3 grants with easy_t=1, mode=0 -> spawn=1,1,0; 4th grant spawn=1.
